// File: rtl/dvs_ravens_pkg.sv
// Shared DVS/RAVENS types: event field widths, packed event record, FIFO default depth.
// Ports: none (package). Provides dvs_event_t and the helper make_dvs_event().
// Imported by the event FIFO, its storage and its handshake interface.
package dvs_ravens_pkg;

   localparam int DVS_X_ADDR_BITS      = 9;
   localparam int DVS_Y_ADDR_BITS      = 9;
   localparam int TIMESTAMP_US_BITS    = 32;
   localparam int DVS_EVENT_FIFO_DEPTH = 16;

   typedef struct packed {
      logic [TIMESTAMP_US_BITS-1:0] timestamp;
      logic [DVS_Y_ADDR_BITS-1:0]   y;
      logic [DVS_X_ADDR_BITS-1:0]   x;
      logic                         polarity;
   } dvs_event_t;

   function automatic dvs_event_t make_dvs_event(
      input logic [DVS_X_ADDR_BITS-1:0]   x,
      input logic [DVS_Y_ADDR_BITS-1:0]   y,
      input logic [TIMESTAMP_US_BITS-1:0] ts,
      input logic                         pol
   );
      dvs_event_t ev;
      ev.timestamp = ts;
      ev.y         = y;
      ev.x         = x;
      ev.polarity  = pol;
      return ev;
   endfunction

endpackage

// File: rtl/dvs_event_fifo_if.sv
// Event stream bundle: AER-side write strobe with event fields, RAVENS-side valid/ready head.
// Ports: in_valid/in_x/in_y/in_timestamp/in_polarity (producer), out_* plus out_ready (consumer).
// master = testbench/producer+consumer view, slave = FIFO view.
interface dvs_event_fifo_if;
   import dvs_ravens_pkg::*;

   logic                         in_valid;
   logic [DVS_X_ADDR_BITS-1:0]   in_x;
   logic [DVS_Y_ADDR_BITS-1:0]   in_y;
   logic [TIMESTAMP_US_BITS-1:0] in_timestamp;
   logic                         in_polarity;

   logic                         out_valid;
   logic                         out_ready;
   logic [DVS_X_ADDR_BITS-1:0]   out_x;
   logic [DVS_Y_ADDR_BITS-1:0]   out_y;
   logic [TIMESTAMP_US_BITS-1:0] out_timestamp;
   logic                         out_polarity;

   modport master (
      output in_valid, in_x, in_y, in_timestamp, in_polarity, out_ready,
      input  out_valid, out_x, out_y, out_timestamp, out_polarity
   );

   modport slave (
      input  in_valid, in_x, in_y, in_timestamp, in_polarity, out_ready,
      output out_valid, out_x, out_y, out_timestamp, out_polarity
   );

endinterface

// File: rtl/dvs_event_fifo_mem.sv
// Event storage: register array, synchronous write port, asynchronous read port.
// Ports: clk, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (combinational read).
// Contents are not reset; the owner gates the read data while the queue is empty.
module dvs_event_fifo_mem
   import dvs_ravens_pkg::*;
#(
   parameter int DEPTH = DVS_EVENT_FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  dvs_event_t    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output dvs_event_t    rdata_o
);

   dvs_event_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dvs_event_fifo.sv
// DVS event FIFO between the AER receiver and the RAVENS spike interface; first-word fall-through.
// Ports: clk, rst (sync, active-high), bus (event in / head out), clear_stats, occupancy,
// almost_full, overflow, drop_count. Write-to-out_valid latency 1 cycle; writes while full are dropped and counted.
module dvs_event_fifo
   import dvs_ravens_pkg::*;
#(
   parameter int DEPTH             = DVS_EVENT_FIFO_DEPTH,
   parameter int ALMOST_FULL_LEVEL = 12,
   parameter int DROP_CNT_BITS     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   dvs_event_fifo_if.slave          bus,
   input  logic                     clear_stats,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     almost_full,
   output logic                     overflow,
   output logic [DROP_CNT_BITS-1:0] drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]            occ_q, occ_d;
   logic                     af_q, af_d;
   logic                     ovf_q, ovf_d;
   logic [DROP_CNT_BITS-1:0] drop_q, drop_d;

   logic       empty, full;
   logic       do_wr, do_rd, drop;
   dvs_event_t wr_ev, rd_ev, head_ev;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   // without a separate counter.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                  (wr_ptr_q[AW] != rd_ptr_q[AW]);

   // Fullness is judged on the registered state, so a read in the same cycle
   // does not make room for a write that arrives while full.
   assign do_wr = bus.in_valid && !full;
   assign drop  = bus.in_valid && full;
   assign do_rd = bus.out_ready && !empty;

   assign wr_ev = make_dvs_event(bus.in_x, bus.in_y, bus.in_timestamp, bus.in_polarity);

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(do_wr);
      rd_ptr_d = rd_ptr_q + PW'(do_rd);
      occ_d    = wr_ptr_d - rd_ptr_d;
      af_d     = (occ_d >= PW'(ALMOST_FULL_LEVEL));
   end

   // A drop in the same cycle as clear_stats wins: the cleared counter
   // restarts at one and the sticky flag stays set.
   always_comb begin
      ovf_d  = ovf_q;
      drop_d = drop_q;
      if (drop) begin
         ovf_d = 1'b1;
         if (clear_stats) begin
            drop_d = DROP_CNT_BITS'(1);
         end else if (drop_q != {DROP_CNT_BITS{1'b1}}) begin
            drop_d = drop_q + DROP_CNT_BITS'(1);
         end
      end else if (clear_stats) begin
         ovf_d  = 1'b0;
         drop_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         af_q     <= 1'b0;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         af_q     <= af_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end

   dvs_event_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .we_i    (do_wr),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (wr_ev),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (rd_ev)
   );

   // Head is a pure function of registered pointers and storage, so out_ready
   // has no combinational path to the outputs. Stale storage is masked when empty.
   assign head_ev = empty ? '0 : rd_ev;

   assign bus.out_valid     = !empty;
   assign bus.out_x         = head_ev.x;
   assign bus.out_y         = head_ev.y;
   assign bus.out_timestamp = head_ev.timestamp;
   assign bus.out_polarity  = head_ev.polarity;

   assign occupancy   = occ_q;
   assign almost_full = af_q;
   assign overflow    = ovf_q;
   assign drop_count  = drop_q;

endmodule

// File: tb/tb_dvs_event_fifo.sv
module tb_dvs_event_fifo;
   import dvs_ravens_pkg::*;

   localparam int DEPTH = 16;
   localparam int AFL   = 12;
   localparam int DCB   = 16;
   localparam int DMAX  = 65535;

   logic           clk = 1'b0;
   logic           rst;
   logic           clear_stats;
   logic [4:0]     occupancy;
   logic           almost_full;
   logic           overflow;
   logic [DCB-1:0] drop_count;

   dvs_event_fifo_if bus ();

   dvs_event_fifo #(
      .DEPTH             (DEPTH),
      .ALMOST_FULL_LEVEL (AFL),
      .DROP_CNT_BITS     (DCB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .clear_stats (clear_stats),
      .occupancy   (occupancy),
      .almost_full (almost_full),
      .overflow    (overflow),
      .drop_count  (drop_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: plain queue of events plus stats.
   dvs_event_t mq[$];
   bit         m_ovf;
   int         m_drop;
   int         m_accepted;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input int x, input int y, input logic [31:0] ts,
                        input logic pol, input logic rdy, input logic clr);
      bus.in_valid     = iv;
      bus.in_x         = x[DVS_X_ADDR_BITS-1:0];
      bus.in_y         = y[DVS_Y_ADDR_BITS-1:0];
      bus.in_timestamp = ts;
      bus.in_polarity  = pol;
      bus.out_ready    = rdy;
      clear_stats      = clr;
   endtask

   // Applies the queue rules to the inputs present at this edge.
   task automatic model_edge();
      bit was_full, rd, wr, dr;
      if (rst) begin
         mq.delete();
         m_ovf  = 0;
         m_drop = 0;
      end else begin
         was_full = (mq.size() == DEPTH);
         rd = (mq.size() > 0) && bus.out_ready;
         wr = bus.in_valid && !was_full;
         dr = bus.in_valid && was_full;
         if (rd) void'(mq.pop_front());
         if (wr) begin
            mq.push_back(make_dvs_event(bus.in_x, bus.in_y, bus.in_timestamp, bus.in_polarity));
            m_accepted++;
         end
         if (dr) begin
            m_ovf  = 1;
            m_drop = clear_stats ? 1 : ((m_drop == DMAX) ? DMAX : m_drop + 1);
         end else if (clear_stats) begin
            m_ovf  = 0;
            m_drop = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic model_check(input string tag);
      dvs_event_t h;
      h = (mq.size() > 0) ? mq[0] : '0;
      chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(mq.size() > 0));
      chk({tag, ".out_x"}, 64'(bus.out_x), 64'(h.x));
      chk({tag, ".out_y"}, 64'(bus.out_y), 64'(h.y));
      chk({tag, ".out_ts"}, 64'(bus.out_timestamp), 64'(h.timestamp));
      chk({tag, ".out_pol"}, 64'(bus.out_polarity), 64'(h.polarity));
      chk({tag, ".occupancy"}, 64'(occupancy), 64'(mq.size()));
      chk({tag, ".almost_full"}, 64'(almost_full), 64'(mq.size() >= AFL));
      chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
      chk({tag, ".drop_count"}, 64'(drop_count), 64'(m_drop));
   endtask

   typedef struct {
      logic        rst;
      logic        iv;
      int          x;
      int          y;
      logic [31:0] ts;
      logic        pol;
      logic        rdy;
      logic        e_vld;
      int          e_x;
      int          e_y;
      logic [31:0] e_ts;
      logic        e_pol;
      int          e_occ;
   } vec_t;

   function automatic vec_t mkv(logic r, logic iv, int x, int y, logic [31:0] ts, logic pol,
                                logic rdy, logic ev, int ex, int ey, logic [31:0] ets,
                                logic ep, int eo);
      vec_t v;
      v.rst = r; v.iv = iv; v.x = x; v.y = y; v.ts = ts; v.pol = pol; v.rdy = rdy;
      v.e_vld = ev; v.e_x = ex; v.e_y = ey; v.e_ts = ets; v.e_pol = ep; v.e_occ = eo;
      return v;
   endfunction

   function automatic dvs_event_t seq_ev(int i);
      return make_dvs_event(i[8:0], 9'(i + 100), 32'hA000 + 32'(i), i[0]);
   endfunction

   vec_t vecs[14];

   initial begin
      int budget;
      dvs_event_t e;

      // Expected values in the table are hand-derived constants.
      vecs[0]  = mkv(1, 1, 5, 6, 32'h7, 1, 0,   0, 0, 0, 0, 0, 0);
      vecs[1]  = mkv(1, 1, 5, 6, 32'h7, 1, 0,   0, 0, 0, 0, 0, 0);
      vecs[2]  = mkv(0, 1, 345, 200, 32'h1234, 1, 0,   1, 345, 200, 32'h1234, 1, 1);
      for (int i = 3; i <= 7; i++)
         vecs[i] = mkv(0, 0, 0, 0, 0, 0, 0,   1, 345, 200, 32'h1234, 1, 1);
      vecs[8]  = mkv(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
      vecs[9]  = mkv(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
      vecs[10] = mkv(0, 1, 7, 8, 32'h9, 0, 1,   1, 7, 8, 32'h9, 0, 1);
      vecs[11] = mkv(0, 1, 10, 11, 32'hC, 1, 1,   1, 10, 11, 32'hC, 1, 1);
      vecs[12] = mkv(0, 0, 0, 0, 0, 0, 0,   1, 10, 11, 32'hC, 1, 1);
      vecs[13] = mkv(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);

      rst = 1'b1;
      m_accepted = 0;
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();

      // ---- table-driven: reset, single event hold, pop, empty-ready, r+w ----
      foreach (vecs[i]) begin
         rst = vecs[i].rst;
         drive(vecs[i].iv, vecs[i].x, vecs[i].y, vecs[i].ts, vecs[i].pol, vecs[i].rdy, 0);
         tick();
         chk($sformatf("vec%0d.out_valid", i), 64'(bus.out_valid), 64'(vecs[i].e_vld));
         chk($sformatf("vec%0d.out_x", i), 64'(bus.out_x), 64'(vecs[i].e_x));
         chk($sformatf("vec%0d.out_y", i), 64'(bus.out_y), 64'(vecs[i].e_y));
         chk($sformatf("vec%0d.out_ts", i), 64'(bus.out_timestamp), 64'(vecs[i].e_ts));
         chk($sformatf("vec%0d.out_pol", i), 64'(bus.out_polarity), 64'(vecs[i].e_pol));
         chk($sformatf("vec%0d.occupancy", i), 64'(occupancy), 64'(vecs[i].e_occ));
         chk($sformatf("vec%0d.overflow", i), 64'(overflow), 64'(0));
         chk($sformatf("vec%0d.drop_count", i), 64'(drop_count), 64'(0));
      end

      // ---- fill and overflow: 20 writes, no reads ----
      for (int i = 0; i < 20; i++) begin
         e = seq_ev(i);
         drive(1, int'(e.x), int'(e.y), e.timestamp, e.polarity, 0, 0);
         tick();
         model_check($sformatf("fill%0d", i));
         if (i == 10) chk("fill.af_after_11", 64'(almost_full), 64'(0));
         if (i == 11) chk("fill.af_after_12", 64'(almost_full), 64'(1));
      end
      chk("fill.occupancy", 64'(occupancy), 64'(16));
      chk("fill.overflow", 64'(overflow), 64'(1));
      chk("fill.drop_count", 64'(drop_count), 64'(4));

      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain%0d.x", i), 64'(bus.out_x), 64'(i));
         chk($sformatf("drain%0d.ts", i), 64'(bus.out_timestamp), 64'(32'hA000 + i));
         drive(0, 0, 0, 0, 0, 1, 0);
         tick();
      end
      model_check("drained");

      // ---- full with simultaneous read and write ----
      for (int i = 0; i < 16; i++) begin
         e = seq_ev(i + 40);
         drive(1, int'(e.x), int'(e.y), e.timestamp, e.polarity, 0, 0);
         tick();
      end
      drive(1, 500, 501, 32'hDEAD, 1, 1, 0);
      tick();
      chk("fullrw.occupancy", 64'(occupancy), 64'(15));
      chk("fullrw.drop_count", 64'(drop_count), 64'(5));
      chk("fullrw.head_x", 64'(bus.out_x), 64'(41));
      model_check("fullrw");
      for (int i = 0; i < 15; i++) begin
         drive(0, 0, 0, 0, 0, 1, 0);
         tick();
         model_check($sformatf("fullrw_drain%0d", i));
      end

      // ---- randomized streaming against the model ----
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      rst = 1'b0;
      m_accepted = 0;
      budget = 0;
      while (m_accepted < 100 && budget < 3000) begin
         drive($urandom_range(0, 1), $urandom_range(0, 511), $urandom_range(0, 511),
               $urandom, $urandom_range(0, 1), $urandom_range(0, 1), 0);
         tick();
         model_check("stream");
         budget++;
      end
      chk("stream.accepted", 64'(m_accepted), 64'(100));
      chk("stream.wraps_ge6", 64'(m_accepted / DEPTH >= 6), 64'(1));
      chk("stream.no_drop", 64'(drop_count), 64'(m_drop));
      budget = 0;
      while (bus.out_valid && budget < 40) begin
         drive(0, 0, 0, 0, 0, 1, 0);
         tick();
         model_check("stream_drain");
         budget++;
      end
      chk("stream.drained", 64'(bus.out_valid), 64'(0));

      // ---- stats: saturation and clear ----
      for (int i = 0; i < 16; i++) begin
         e = seq_ev(i);
         drive(1, int'(e.x), int'(e.y), e.timestamp, e.polarity, 0, 0);
         tick();
      end
      for (int i = 0; i < 70000; i++) begin
         drive(1, 1, 2, 32'h3, 0, 0, 0);
         tick();
      end
      chk("stats.saturated", 64'(drop_count), 64'(16'hFFFF));
      model_check("stats_sat");
      drive(0, 0, 0, 0, 0, 0, 1);
      tick();
      chk("stats.clear_count", 64'(drop_count), 64'(0));
      chk("stats.clear_ovf", 64'(overflow), 64'(0));
      drive(1, 1, 2, 32'h3, 0, 0, 1);
      tick();
      chk("stats.clr_drop_count", 64'(drop_count), 64'(1));
      chk("stats.clr_drop_ovf", 64'(overflow), 64'(1));
      model_check("stats_clr_drop");

      // ---- reset mid-burst with in_valid held ----
      rst = 1'b1;
      drive(1, 9, 9, 32'h9, 1, 0, 0);
      tick();
      tick();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("rst2.occupancy", 64'(occupancy), 64'(0));
      chk("rst2.out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst2.overflow", 64'(overflow), 64'(0));
      chk("rst2.drop_count", 64'(drop_count), 64'(0));
      chk("rst2.out_x", 64'(bus.out_x), 64'(0));
      chk("rst2.almost_full", 64'(almost_full), 64'(0));
      tick();
      model_check("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
